tick_gen_ctrl: RTL

- Upstream stage for every clock-enabled register in the datapath, including the historical-bit flip-flops.
- Generates the single-cycle Tick strobe that those registers AND with ClockEnable.
- Supports free-run at a programmable divide ratio, halt, and single-step debug.
- One instance sits at the top level and fans Tick out to all register banks.

---
 rtl/tick_gen_pkg.sv | 10 +
 rtl/tick_div_counter.sv | 33 +++
 rtl/tick_gen_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: FSM state encodings and counter widths.
package tick_gen_pkg;

  localparam logic [1:0] HALT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  localparam int unsigned TICK_COUNT_W = 32;

endpackage

// File: rtl/tick_div_counter.sv
// Loadable down-counter for the tick period; reloads with max(ratio,1)-1 and flags zero.
module tick_div_counter #(
  parameter int unsigned NrOfBits = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                clear,
  input  logic                load,
  input  logic                dec,
  input  logic [NrOfBits-1:0] ratio,
  output logic                zero_c
);

  logic [NrOfBits-1:0] cnt;
  logic [NrOfBits-1:0] reload_c;

  // Ratios 0 and 1 both reload to 0, giving a tick every cycle.
  assign reload_c = (ratio == '0) ? '0 : ratio - NrOfBits'(1);
  assign zero_c   = (cnt == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_c;
    end else if (dec && !zero_c) begin
      cnt <= cnt - NrOfBits'(1);
    end
  end

endmodule

// File: rtl/tick_gen_ctrl.sv
// Tick strobe generator with free-run, halt and single-step; registered Tick/Running/StepBusy.
// Optional TICK_GEN_COUNT_EN adds a 32-bit TickCount with synchronous CountClear.
module tick_gen_ctrl
  import tick_gen_pkg::*;
#(
  parameter int unsigned NrOfBits     = 16,
  parameter int unsigned ResetDivider = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Run,
  input  logic                    Step,
  input  logic                    DividerLoad,
  input  logic [NrOfBits-1:0]     DividerValue,
`ifdef TICK_GEN_COUNT_EN
  input  logic                    CountClear,
  output logic [TICK_COUNT_W-1:0] TickCount,
`endif
  output logic                    Tick,
  output logic                    Running,
  output logic                    StepBusy
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                tick_nxt;
  logic                running_nxt;
  logic                step_busy_nxt;
  logic                cnt_clear_c;
  logic                cnt_load_c;
  logic                cnt_dec_c;
  logic                cnt_zero_c;
  logic [NrOfBits-1:0] div_reg;

  // Latched divide ratio; the counter samples the pre-load value on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_reg <= NrOfBits'(ResetDivider);
    end else if (DividerLoad) begin
      div_reg <= DividerValue;
    end
  end

  tick_div_counter #(
    .NrOfBits(NrOfBits)
  ) u_div_counter (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (cnt_clear_c),
    .load   (cnt_load_c),
    .dec    (cnt_dec_c),
    .ratio  (div_reg),
    .zero_c (cnt_zero_c)
  );

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= HALT;
      Tick     <= 1'b0;
      Running  <= 1'b0;
      StepBusy <= 1'b0;
    end else begin
      state    <= state_nxt;
      Tick     <= tick_nxt;
      Running  <= running_nxt;
      StepBusy <= step_busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    tick_nxt      = 1'b0;
    step_busy_nxt = 1'b0;
    cnt_clear_c   = 1'b0;
    cnt_load_c    = 1'b0;
    cnt_dec_c     = 1'b0;
    case (state)
      HALT: begin
        if (Run) begin
          state_nxt  = RUN;
          cnt_load_c = 1'b1;
        end else if (Step) begin
          state_nxt     = STEP;
          step_busy_nxt = 1'b1;
        end
      end
      RUN: begin
        // Dropping Run wins over a tick due in the same cycle.
        if (!Run) begin
          state_nxt   = HALT;
          cnt_clear_c = 1'b1;
        end else if (cnt_zero_c) begin
          tick_nxt   = 1'b1;
          cnt_load_c = 1'b1;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      STEP: begin
        tick_nxt  = 1'b1;
        state_nxt = HALT;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
    running_nxt = (state_nxt == RUN);
  end

`ifdef TICK_GEN_COUNT_EN
  // Counts cycles with Tick high; clear has priority over a coincident increment.
  always_ff @(posedge Clock) begin
    if (Reset || CountClear) begin
      TickCount <= '0;
    end else if (Tick) begin
      TickCount <= TickCount + TICK_COUNT_W'(1);
    end
  end
`endif

endmodule
